// File: rtl/audio_stream_ctrl.sv
`timescale 1ns/1ps
// audio_stream_ctrl
//
// Playback scheduler between the sample FIFO and the sigma-delta DAC.
// A free-running rate divider produces one tick per sample period; while
// playing, each tick pulls one sample from the FIFO and, two cycles later,
// strobes the DAC. Playback only starts (or resumes after an underrun) once
// the FIFO has been refilled to START_LEVEL. Host flow control (rx_ready)
// is driven from the fill level with hysteresis.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   enable         playback enable (level)
//   rate_sel       0=11025, 1=22050, 2=44100, 3=48000 Hz
//   fifo_fill      current FIFO occupancy
//   fifo_empty     FIFO empty flag
//   fifo_full      FIFO full flag
//   fifo_rd_en     one-cycle FIFO read strobe (cycle after the tick)
//   dac_ce         one-cycle DAC update strobe (cycle after fifo_rd_en)
//   dac_reset      holds the DAC in reset while not playing
//   rx_ready       host flow control (CTS), hysteretic
//   underrun_count saturating count of underruns, cleared only by reset
//   state          0=IDLE, 1=PREFILL, 2=PLAY
module audio_stream_ctrl #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int FIFO_SIZE   = 16384,
    parameter int FILL_BITS   = $clog2(FIFO_SIZE),
    parameter int START_LEVEL = FIFO_SIZE / 2,
    parameter int LOW_MARK    = FIFO_SIZE / 10,
    parameter int HIGH_MARK   = FIFO_SIZE - 2 * (FIFO_SIZE / 10)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           rate_sel,
    input  logic [FILL_BITS-1:0] fifo_fill,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    output logic                 fifo_rd_en,
    output logic                 dac_ce,
    output logic                 dac_reset,
    output logic                 rx_ready,
    output logic [7:0]           underrun_count,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    // Sample rate in Hz for each rate_sel code.
    function automatic int rate_hz(input int idx);
        case (idx)
            0:       return 11025;
            1:       return 22050;
            2:       return 44100;
            default: return 48000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Divider reload table: DIV-1 for each rate, DIV = CLK_FREQ / rate.
    // ------------------------------------------------------------------
    logic [10:0] reload_tbl [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_reload
            localparam int DIV = CLK_FREQ / rate_hz(gi);
            assign reload_tbl[gi] = 11'(DIV - 1);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Rate divider. Runs in every state. rate_sel is only looked at on a
    // reload, so a change never shortens the period already in progress.
    // ------------------------------------------------------------------
    logic [10:0] div_reg;
    logic        tick;

    assign tick = (div_reg == 11'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= reload_tbl[rate_sel];
        end else if (tick) begin
            div_reg <= reload_tbl[rate_sel];
        end else begin
            div_reg <= div_reg - 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // Fill-level comparisons, done at 32 bits so the thresholds need no
    // width juggling.
    // ------------------------------------------------------------------
    logic [31:0] fill_ext;
    logic        start_met;
    logic        at_high;
    logic        at_low;

    assign fill_ext  = 32'(fifo_fill);
    assign start_met = (fill_ext >= 32'(START_LEVEL)) || fifo_full;
    assign at_high   = (fill_ext >= 32'(HIGH_MARK)) || fifo_full;
    assign at_low    = (fill_ext <= 32'(LOW_MARK)) && !fifo_full;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t      state_reg;
    state_t      state_next;
    logic        rd_en_reg;
    logic        rd_en_next;
    logic        dac_ce_reg;
    logic        dac_ce_next;
    logic        dac_reset_reg;
    logic        dac_reset_next;
    logic        rx_ready_reg;
    logic        rx_ready_next;
    logic [7:0]  count_reg;
    logic [7:0]  count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rd_en_reg     <= 1'b0;
            dac_ce_reg    <= 1'b0;
            dac_reset_reg <= 1'b1;
            rx_ready_reg  <= 1'b1;
            count_reg     <= 8'd0;
        end else begin
            state_reg     <= state_next;
            rd_en_reg     <= rd_en_next;
            dac_ce_reg    <= dac_ce_next;
            dac_reset_reg <= dac_reset_next;
            rx_ready_reg  <= rx_ready_next;
            count_reg     <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rd_en_next    = 1'b0;
        count_next    = count_reg;
        rx_ready_next = rx_ready_reg;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_PREFILL;
                end
            end
            ST_PREFILL: begin
                if (start_met) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (fifo_empty) begin
                        // Underrun: go back to refilling before playing on.
                        state_next = ST_PREFILL;
                        if (count_reg != 8'hFF) begin
                            count_next = count_reg + 8'd1;
                        end
                    end else begin
                        rd_en_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disable overrides everything decided above, including a read or
        // an underrun landing in the same cycle.
        if (!enable) begin
            state_next = ST_IDLE;
            rd_en_next = 1'b0;
            count_next = count_reg;
        end

        // The DAC strobe follows the read by one cycle, but only if we are
        // still playing; a sample read just before leaving PLAY is dropped.
        dac_ce_next = rd_en_reg && (state_next == ST_PLAY);

        // Registered from state_next so dac_reset moves with the state.
        dac_reset_next = (state_next != ST_PLAY);

        // Hysteretic flow control: between the marks the last value holds.
        if (at_high) begin
            rx_ready_next = 1'b0;
        end else if (at_low) begin
            rx_ready_next = 1'b1;
        end
    end

    assign fifo_rd_en     = rd_en_reg;
    assign dac_ce         = dac_ce_reg;
    assign dac_reset      = dac_reset_reg;
    assign rx_ready       = rx_ready_reg;
    assign underrun_count = count_reg;
    assign state          = state_reg;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for audio_stream_ctrl at default parameters
// (12 MHz clock, 16384-entry FIFO).
module tb_audio_stream_ctrl;

    localparam int CLK_HZ = 12_000_000;
    localparam int FSIZE  = 16384;
    localparam int START  = FSIZE / 2;
    localparam int LOW    = FSIZE / 10;
    localparam int HIGH   = FSIZE - 2 * (FSIZE / 10);

    function automatic int div_of(input int r);
        case (r)
            0:       return CLK_HZ / 11025;
            1:       return CLK_HZ / 22050;
            2:       return CLK_HZ / 44100;
            default: return CLK_HZ / 48000;
        endcase
    endfunction

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  rate_sel;
    logic [13:0] fifo_fill;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_rd_en;
    logic        dac_ce;
    logic        dac_reset;
    logic        rx_ready;
    logic [7:0]  underrun_count;
    logic [1:0]  state;

    int tests;
    int fails;
    int edge_n;

    audio_stream_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .rate_sel       (rate_sel),
        .fifo_fill      (fifo_fill),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_rd_en     (fifo_rd_en),
        .dac_ce         (dac_ce),
        .dac_reset      (dac_reset),
        .rx_ready       (rx_ready),
        .underrun_count (underrun_count),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    // Stimulus helper: hold reset for n edges, release on a falling edge.
    task automatic do_reset(input logic [1:0] r, input int n);
        @(negedge clk);
        reset    = 1'b1;
        rate_sel = r;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) for the next fifo_rd_en; reports the edge index it
    // appeared after and how many dac_ce pulses were seen on the way.
    task automatic wait_rd(input int limit, output int at, output int ce_seen, output bit ok);
        int i;
        ok = 1'b0; at = -1; ce_seen = 0; i = 0;
        while (!ok && i < limit) begin
            @(negedge clk);
            i++;
            if (fifo_rd_en === 1'b1) begin
                ok = 1'b1;
                at = edge_n;
            end else if (dac_ce === 1'b1) begin
                ce_seen++;
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        logic [13:0] exp;
        enable     = 1'b1;
        fifo_fill  = 14'($urandom_range(0, FSIZE - 1));
        fifo_empty = 1'b0;
        fifo_full  = 1'b0;
        rate_sel   = 2'($urandom_range(0, 3));
        @(negedge clk);
        reset = 1'b1;
        exp = {2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = {state, fifo_rd_en, dac_ce, dac_reset, rx_ready, underrun_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL reset_values cycle %0d: got %b expected %b", c, got, exp);
            end
        end
        reset = 1'b0;
        $display("[TB] reset held 5 cycles with enable=1");
    endtask

    task automatic test_prefill_play(input logic [1:0] r, input bit use_full, input int npulses);
        int div, hold, bad, at, ce_seen;
        bit ok;
        div = div_of(r);
        enable = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
        fifo_fill = 14'(START - 1);
        do_reset(r, 2);
        hold = $urandom_range(5, 40);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (state !== 2'd1 || dac_reset !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
            fifo_fill = (i == hold - 1) ? 14'(START - 1) : 14'($urandom_range(0, START - 1));
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL prefill_hold rate %0d: %0d bad cycles, expected 0", r, bad);
        end
        if (use_full) begin
            fifo_full = 1'b1;
            fifo_fill = 14'($urandom_range(0, START - 1));
        end else begin
            fifo_fill = 14'(START);
        end
        @(negedge clk);
        tests++;
        if (state !== 2'd2 || dac_reset !== 1'b0) begin
            fails++;
            $display("FAIL prefill_to_play rate %0d full %0d: state %0d dac_reset %0d, expected 2 0",
                     r, use_full, state, dac_reset);
        end
        fifo_full = 1'b0;
        fifo_fill = 14'(START);
        for (int k = 1; k <= npulses; k++) begin
            wait_rd(div + 5, at, ce_seen, ok);
            tests++;
            if (!ok || at != k * div || ce_seen != 0) begin
                fails++;
                $display("FAIL read_timing rate %0d pulse %0d: at edge %0d (found %0d, stray ce %0d), expected edge %0d",
                         r, k, at, ok, ce_seen, k * div);
            end
            @(negedge clk);
            tests++;
            if (dac_ce !== 1'b1 || fifo_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL dac_ce_follow rate %0d pulse %0d: dac_ce %0d rd_en %0d, expected 1 0",
                         r, k, dac_ce, fifo_rd_en);
            end
            $display("[TB] rate %0d read %0d at edge %0d", r, k, at);
        end
    endtask

    task automatic test_underrun(input int n);
        int guard, stray, exp_cnt;
        logic [11:0] got;
        logic [11:0] exp;
        enable = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
        fifo_fill = 14'(START);
        do_reset(2'd3, 2);
        stray = 0;
        for (int k = 1; k <= n; k++) begin
            guard = 0;
            while ((edge_n % 250) != 249 && guard < 300) begin
                @(negedge clk);
                guard++;
                if (fifo_rd_en === 1'b1) stray++;
            end
            if (guard >= 300) begin
                tests++; fails++;
                $display("FAIL underrun_tick_wait: timed out at iteration %0d, expected tick", k);
                return;
            end
            fifo_empty = 1'b1;
            @(negedge clk);
            exp_cnt = (k > 255) ? 255 : k;
            exp = {2'd1, 1'b0, 1'b1, 8'(exp_cnt)};
            got = {state, fifo_rd_en, dac_reset, underrun_count};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL underrun %0d: state/rd/dac_reset/count got %b expected %b", k, got, exp);
            end
            $display("[TB] underrun %0d count=%0d", k, underrun_count);
            fifo_empty = 1'b0;
        end
        tests++;
        if (stray != 0) begin
            fails++;
            $display("FAIL underrun_no_reads: %0d reads seen, expected 0", stray);
        end
    endtask

    task automatic test_rx_ready();
        int fills[$];
        bit fulls[$];
        int v;
        bit exp_rx;
        enable = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0; fifo_fill = 14'd0;
        do_reset(2'd0, 2);
        v = 0;
        fills.push_back(0); fulls.push_back(1'b0);
        while (v < HIGH - 1) begin
            v += $urandom_range(200, 1500);
            if (v > HIGH - 1) v = HIGH - 1;
            fills.push_back(v); fulls.push_back(1'b0);
        end
        fills.push_back(HIGH);                             fulls.push_back(1'b0);
        fills.push_back(HIGH + $urandom_range(0, 3275));   fulls.push_back(1'b0);
        v = HIGH - 1;
        fills.push_back(v); fulls.push_back(1'b0);
        while (v > LOW + 1) begin
            v -= $urandom_range(200, 1500);
            if (v < LOW + 1) v = LOW + 1;
            fills.push_back(v); fulls.push_back(1'b0);
        end
        fills.push_back(LOW);                        fulls.push_back(1'b0);
        fills.push_back($urandom_range(0, LOW));     fulls.push_back(1'b0);
        fills.push_back(0);                          fulls.push_back(1'b0);
        fills.push_back(5000);                       fulls.push_back(1'b1);
        fills.push_back(5000);                       fulls.push_back(1'b0);
        fills.push_back(LOW);                        fulls.push_back(1'b0);
        fills.push_back(100);                        fulls.push_back(1'b1);
        fills.push_back(100);                        fulls.push_back(1'b0);
        exp_rx = 1'b1;
        for (int i = 0; i < fills.size(); i++) begin
            fifo_fill = 14'(fills[i]);
            fifo_full = fulls[i];
            if (fills[i] >= HIGH || fulls[i]) exp_rx = 1'b0;
            else if (fills[i] <= LOW)         exp_rx = 1'b1;
            @(negedge clk);
            tests++;
            if (rx_ready !== exp_rx) begin
                fails++;
                $display("FAIL rx_ready fill %0d full %0d: got %0d expected %0d",
                         fills[i], fulls[i], rx_ready, exp_rx);
            end
            $display("[TB] rx step fill=%0d full=%0d rx_ready=%0d", fills[i], fulls[i], rx_ready);
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_enable_drop();
        int at, ce_seen, bad;
        bit ok;
        logic [13:0] got;
        logic [13:0] exp;
        enable = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
        fifo_fill = 14'(START);
        do_reset(2'd2, 2);
        wait_rd(300, at, ce_seen, ok);
        tests++;
        if (!ok || at != 272) begin
            fails++;
            $display("FAIL drop_first_read: at edge %0d (found %0d), expected edge 272", at, ok);
        end
        enable = 1'b0;
        @(negedge clk);
        tests++;
        if (state !== 2'd0 || dac_ce !== 1'b0 || dac_reset !== 1'b1 || fifo_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL enable_drop: state %0d dac_ce %0d dac_reset %0d rd_en %0d, expected 0 0 1 0",
                     state, dac_ce, dac_reset, fifo_rd_en);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (dac_ce !== 1'b0 || state !== 2'd0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_after_drop: %0d bad cycles, expected 0", bad);
        end
        $display("[TB] enable dropped during read at edge %0d", at);
        // Reset arriving in the read cycle must cancel the pending dac_ce.
        enable = 1'b1;
        wait_rd(300, at, ce_seen, ok);
        tests++;
        if (!ok || at != 544) begin
            fails++;
            $display("FAIL reenable_read: at edge %0d (found %0d), expected edge 544", at, ok);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp = {2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        got = {state, fifo_rd_en, dac_ce, dac_reset, rx_ready, underrun_count};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL reset_mid_read: got %b expected %b", got, exp);
        end
        $display("[TB] reset during read at edge %0d", at);
    endtask

    task automatic test_rate_change();
        int at, ce_seen, exp_at;
        bit ok;
        enable = 1'b1; fifo_empty = 1'b0; fifo_full = 1'b0;
        fifo_fill = 14'(START);
        do_reset(2'd0, 2);
        wait_rd(1100, at, ce_seen, ok);
        tests++;
        if (!ok || at != 1088) begin
            fails++;
            $display("FAIL rate_first_read: at edge %0d (found %0d), expected edge 1088", at, ok);
        end
        repeat ($urandom_range(20, 900)) @(negedge clk);
        rate_sel = 2'd2;
        exp_at = 2 * 1088;
        for (int k = 0; k < 3; k++) begin
            wait_rd(1100, at, ce_seen, ok);
            tests++;
            if (!ok || at != exp_at || ce_seen != 0) begin
                fails++;
                $display("FAIL rate_change read %0d: at edge %0d (found %0d, stray ce %0d), expected edge %0d",
                         k, at, ok, ce_seen, exp_at);
            end
            @(negedge clk);
            tests++;
            if (dac_ce !== 1'b1) begin
                fails++;
                $display("FAIL rate_change dac_ce %0d: got %0d expected 1", k, dac_ce);
            end
            $display("[TB] rate change read %0d at edge %0d", k, at);
            exp_at += 272;
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0; enable = 1'b0; rate_sel = 2'd0;
        fifo_fill = 14'd0; fifo_empty = 1'b0; fifo_full = 1'b0;
        test_reset();
        test_prefill_play(2'd0, 1'b0, 3);
        test_prefill_play(2'($urandom_range(1, 3)), 1'b1, 3);
        test_rx_ready();
        test_enable_drop();
        test_rate_change();
        test_underrun(257);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
